// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the EX stage and the multiply/divide sequencer
interface muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            stall;
  modport master(output start, op, rs1, rs2, flush, input busy, done, result, stall);
  modport slave(input start, op, rs1, rs2, flush, output busy, done, result, stall);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer (radix-2, XLEN iterations)
// Define MULDIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow right after start.
module muldiv_seq #(parameter int XLEN = 32) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t                    state;
  logic [$clog2(XLEN)-1:0]   cnt;
  logic [XLEN-1:0]           a, hi, lo;
  logic [2:0]                op_r;
  logic                      neg;
  logic                      s1, s2, div_zero, ovf, early, ge;
  logic [XLEN-1:0]           m1, m2, spec_val, df, qn, rn, fixed;
  logic [XLEN:0]             sum, sh;
  logic [2*XLEN-1:0]         pn;
  assign s1       = bus.rs1[XLEN-1] & (bus.op[2] ? ~bus.op[0] : bus.op[1] ^ bus.op[0]);
  assign s2       = bus.rs2[XLEN-1] & (bus.op[2] ? ~bus.op[0] : bus.op[1:0] == 2'b01);
  assign m1       = s1 ? -bus.rs1 : bus.rs1;
  assign m2       = s2 ? -bus.rs2 : bus.rs2;
  assign div_zero = bus.op[2] & ~|bus.rs2;
  assign ovf      = bus.op[2] & ~bus.op[0] & (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.rs2);
  assign spec_val = div_zero ? (bus.op[1] ? bus.rs1 : '1) : (bus.op[1] ? '0 : bus.rs1);
`ifdef MULDIV_EARLY_OUT_EN
  assign early = div_zero | ovf;
`else
  assign early = 1'b0;
`endif
  // hi:lo is the product accumulator for MUL*, remainder:quotient for DIV*
  assign sum   = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
  assign sh    = {hi, lo[XLEN-1]};
  assign ge    = sh >= {1'b0, a};
  assign df    = sh[XLEN-1:0] - a;
  assign pn    = neg ? -{hi, lo} : {hi, lo};
  assign qn    = neg ? -lo : lo;
  assign rn    = neg ? -hi : hi;
  assign fixed = op_r[2] ? (op_r[1] ? rn : qn) : (op_r[1:0] == 2'b00 ? pn[XLEN-1:0] : pn[2*XLEN-1:XLEN]);
  assign bus.stall = (state == IDLE && bus.start && !bus.flush) || state == CALC || state == FIX;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      a          <= '0;
      hi         <= '0;
      lo         <= '0;
      op_r       <= '0;
      neg        <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
    end else if (bus.flush) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op_r     <= bus.op;
          // divide by zero keeps an unsigned all-ones quotient, so no negate for DIV
          neg      <= (bus.op[2] & bus.op[1]) ? s1 : (s1 ^ s2) & ~div_zero;
          a        <= bus.op[2] ? m2 : m1;
          lo       <= bus.op[2] ? m1 : m2;
          hi       <= '0;
          cnt      <= '0;
          state    <= early ? DONE : CALC;
          bus.busy <= ~early;
          bus.done <= early;
          if (early) bus.result <= spec_val;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          hi  <= op_r[2] ? (ge ? df : sh[XLEN-1:0]) : sum[XLEN:1];
          lo  <= op_r[2] ? {lo[XLEN-2:0], ge} : {sum[0], lo[XLEN-1:1]};
          if (cnt == $bits(cnt)'(XLEN-1)) state <= FIX;
        end
        FIX: begin
          state      <= DONE;
          bus.busy   <= 1'b0;
          bus.done   <= 1'b1;
          bus.result <= fixed;
        end
        default: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq against an arithmetic reference model
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  muldiv_if #(.XLEN(32)) bus();
  muldiv_seq #(.XLEN(32)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pu;
    logic signed [63:0] ps;
    int sa, sb;
    logic ov;
    sa = $signed(a);
    sb = $signed(b);
    pu = {32'b0, a} * {32'b0, b};
    ov = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (op)
      3'd0: return pu[31:0];
      3'd1: begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
      3'd2: begin ps = longint'(sa) * longint'({32'b0, b}); return ps[63:32]; end
      3'd3: return pu[63:32];
      3'd4: return (b == 0) ? 32'hFFFFFFFF : ov ? a : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: return (b == 0) ? a : ov ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction
  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
`endif
    return 34;
  endfunction
  // Drives one request from an IDLE cycle (just after an edge), returns result and cycles to done
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    bus.start = 1'b1; bus.op = op; bus.rs1 = a; bus.rs2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0; bus.rs1 = '0; bus.rs2 = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_latency;
    bus.start = 1'b1; bus.op = 3'd0; bus.rs1 = 32'd7; bus.rs2 = 32'hFFFFFFFD;
    #1;
    n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL lat_stall_c0: got %b expected 1", bus.stall); end
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c < 34; c++) begin
      n_cmp++;
      if (bus.stall !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL lat_window c%0d: got stall=%b busy=%b done=%b expected 1 1 0", c, bus.stall, bus.busy, bus.done);
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL lat_done_c34: got %b expected 1", bus.done); end
    n_cmp++; if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL lat_c34_idle: got stall=%b busy=%b expected 0 0", bus.stall, bus.busy); end
    n_cmp++; if (bus.result !== 32'hFFFFFFEB) begin n_err++; $display("FAIL lat_mul_result: got %h expected ffffffeb", bus.result); end
    @(posedge clk); #1;
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL lat_done_pulse: got %b expected 0", bus.done); end
  endtask
  task automatic test_directed;
    logic [2:0]  ops [14] = '{3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5};
    logic [31:0] as  [14] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                             32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd9};
    logic [31:0] bs  [14] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7,
                             32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
    logic [31:0] ex  [14] = '{32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                             32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFF};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 14; i++) begin
      issue(ops[i], as[i], bs[i], res, lat);
      n_cmp++; if (res !== ex[i]) begin n_err++; $display("FAIL directed_%0d result: got %h expected %h", i, res, ex[i]); end
      n_cmp++; if (lat !== exp_lat(ops[i], as[i], bs[i])) begin n_err++; $display("FAIL directed_%0d latency: got %0d expected %0d", i, lat, exp_lat(ops[i], as[i], bs[i])); end
    end
  endtask
  task automatic test_ignore_start;
    int lat;
    bus.start = 1'b1; bus.op = 3'd0; bus.rs1 = 32'd1234; bus.rs2 = 32'd5678;
    @(posedge clk); #1;
    lat = 1;
    for (int c = 0; c < 20; c++) begin
      bus.op = 3'd3; bus.rs1 = $urandom; bus.rs2 = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (bus.result !== model(3'd0, 32'd1234, 32'd5678)) begin n_err++; $display("FAIL ignore_start result: got %h expected %h", bus.result, model(3'd0, 32'd1234, 32'd5678)); end
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL ignore_start latency: got %0d expected 34", lat); end
    @(posedge clk); #1;
  endtask
  task automatic test_flush;
    logic [31:0] old, res;
    int lat;
    logic seen;
    issue(3'd3, 32'h12345678, 32'h9ABCDEF0, old, lat);
    bus.start = 1'b1; bus.op = 3'd4; bus.rs1 = 32'd1000; bus.rs2 = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c < 10; c++) begin
      seen |= bus.done;
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b expected 0", bus.stall); end
    n_cmp++; if ((seen | bus.done) !== 1'b0) begin n_err++; $display("FAIL flush_done: got %b expected 0", seen | bus.done); end
    n_cmp++; if (bus.result !== old) begin n_err++; $display("FAIL flush_result: got %h expected %h", bus.result, old); end
    issue(3'd7, 32'd100, 32'd7, res, lat);
    n_cmp++; if (res !== 32'd2) begin n_err++; $display("FAIL flush_restart result: got %h expected 2", res); end
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL flush_restart latency: got %0d expected 34", lat); end
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd0; bus.rs1 = 32'd3; bus.rs2 = 32'd3;
    #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL flush_prio stall: got %b expected 0", bus.stall); end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL flush_prio busy/done: got %b/%b expected 0/0", bus.busy, bus.done); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] res;
    int lat;
    bus.start = 1'b1; bus.op = 3'd0; bus.rs1 = 32'd123; bus.rs2 = 32'd456;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL reset_mid busy/done: got %b/%b expected 0/0", bus.busy, bus.done); end
    n_cmp++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL reset_mid result: got %h expected 0", bus.result); end
    issue(3'd5, 32'd1000, 32'd7, res, lat);
    n_cmp++; if (res !== 32'd142) begin n_err++; $display("FAIL reset_mid restart: got %h expected 8e", res); end
  endtask
  task automatic test_random;
    logic [2:0] op;
    logic [31:0] a, b, res;
    int lat, sel;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom; sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'h0;
      else if (sel == 1) b = 32'hFFFFFFFF;
      else if (sel == 2) b = 32'($urandom_range(1, 20));
      else if (sel == 3) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      issue(op, a, b, res, lat);
      n_cmp++; if (res !== model(op, a, b)) begin n_err++; $display("FAIL random_%0d op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, res, model(op, a, b)); end
      n_cmp++; if (lat !== exp_lat(op, a, b)) begin n_err++; $display("FAIL random_%0d latency: got %0d expected %0d", i, lat, exp_lat(op, a, b)); end
    end
  endtask
  initial begin
    test_reset;
    test_latency;
    test_directed;
    test_ignore_start;
    test_flush;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
